// File: rtl/mc_pkg.sv
// Shared definitions for the multicycle controller: FSM states, RV32I major
// opcodes, and the encodings of the decode fields handed to the datapath.
package mc_pkg;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_TRAP   = 3'd7
    } state_t;

    // Major opcodes
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    // ALU operations: {alt, funct3}
    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b1000;
    localparam logic [3:0] ALU_SLL  = 4'b0001;
    localparam logic [3:0] ALU_SLT  = 4'b0010;
    localparam logic [3:0] ALU_SLTU = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SRL  = 4'b0101;
    localparam logic [3:0] ALU_SRA  = 4'b1101;
    localparam logic [3:0] ALU_OR   = 4'b0110;
    localparam logic [3:0] ALU_AND  = 4'b0111;

    // Immediate formats
    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_U = 3'b011;
    localparam logic [2:0] IMM_J = 3'b100;

    // Branch-unit operation: conditional branches use {2'b00, funct3}
    localparam logic [4:0] BR_JUMP = 5'b01111;
    localparam logic [4:0] BR_NONE = 5'b10101;

    // Register-file write-back source
    localparam logic [1:0] WR_ALU = 2'b00;
    localparam logic [1:0] WR_MEM = 2'b01;
    localparam logic [1:0] WR_PC4 = 2'b10;

    typedef struct packed {
        logic [2:0] imm_src;
        logic       alu_a_src;
        logic       alu_b_src;
        logic [4:0] br_op;
        logic [3:0] alu_op;
        logic [2:0] dm_ctrl;
        logic [1:0] wr_src;
        logic       is_load;
        logic       is_store;
        logic       is_branch;
    } dec_t;

endpackage

// File: rtl/mc_decoder.sv
// Combinational instruction decoder: opcode/funct3/funct7 to datapath control
// fields, instruction class, and an illegal-encoding flag.
module mc_decoder
    import mc_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    output dec_t       dec,
    output logic       illegal
);

    // Decode table; defaults describe a plain ALU op writing back the ALU result
    always_comb begin
        dec       = '0;
        dec.br_op = BR_NONE;
        illegal   = 1'b0;
        case (opcode)
            OP_REG: begin
                dec.alu_op = {funct7[5], funct3};
                // The alternate encoding only exists for sub and sra
                if (funct7 == 7'b0100000) begin
                    if (funct3 != 3'b000 && funct3 != 3'b101)
                        illegal = 1'b1;
                end else if (funct7 != 7'b0000000) begin
                    illegal = 1'b1;
                end
            end
            OP_IMM: begin
                dec.alu_b_src = 1'b1;
                // No subi: funct7[5] only distinguishes srai from srli
                dec.alu_op = (funct3 == 3'b101) ? {funct7[5], funct3} : {1'b0, funct3};
            end
            OP_LOAD: begin
                dec.alu_b_src = 1'b1;
                dec.dm_ctrl   = funct3;
                dec.wr_src    = WR_MEM;
                dec.is_load   = 1'b1;
                if (funct3 == 3'b011 || funct3 == 3'b110 || funct3 == 3'b111)
                    illegal = 1'b1;
            end
            OP_STORE: begin
                dec.imm_src   = IMM_S;
                dec.alu_b_src = 1'b1;
                dec.dm_ctrl   = funct3;
                dec.is_store  = 1'b1;
                if (funct3[2] || funct3 == 3'b011)
                    illegal = 1'b1;
            end
            OP_BRANCH: begin
                dec.imm_src   = IMM_B;
                dec.alu_a_src = 1'b1;
                dec.alu_b_src = 1'b1;
                dec.br_op     = {2'b00, funct3};
                dec.is_branch = 1'b1;
                if (funct3 == 3'b010 || funct3 == 3'b011)
                    illegal = 1'b1;
            end
            OP_JAL: begin
                dec.imm_src   = IMM_J;
                dec.alu_a_src = 1'b1;
                dec.alu_b_src = 1'b1;
                dec.br_op     = BR_JUMP;
                dec.wr_src    = WR_PC4;
            end
            OP_JALR: begin
                dec.alu_b_src = 1'b1;
                dec.br_op     = BR_JUMP;
                dec.wr_src    = WR_PC4;
            end
            OP_LUI: begin
                // Operand A is forced to zero outside this block
                dec.imm_src   = IMM_U;
                dec.alu_b_src = 1'b1;
            end
            OP_AUIPC: begin
                dec.imm_src   = IMM_U;
                dec.alu_a_src = 1'b1;
                dec.alu_b_src = 1'b1;
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle RV32I control FSM: sequences FETCH/DECODE/EXEC/MEM/WB, latches
// decode fields in DECODE, and traps permanently on illegal instructions.
module multicycle_ctrl
    import mc_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] Opcode,
    input  logic [2:0] Funct3,
    input  logic [6:0] Funct7,
    input  logic       IMemReady,
    input  logic       DMemReady,
    input  logic       BrTaken,
    output logic       PCWr,
    output logic       IRWr,
    output logic       RUWr,
    output logic       DMReq,
    output logic       DMWr,
    output logic [2:0] ImmSrc,
    output logic       ALUASrc,
    output logic       ALUBSrc,
    output logic [4:0] BrOp,
    output logic [3:0] ALUOp,
    output logic [2:0] DMCtrl,
    output logic [1:0] RUDataWrSrc,
    output logic       Illegal,
    output logic [2:0] State
);

    state_t state_reg;
    dec_t   dec_reg;
    logic   illegal_reg;
    dec_t   dec_w;
    logic   illegal_w;

    // The branch decision is applied by the PC mux; the FSM writes the PC either way
    logic   unused_brtaken;
    assign unused_brtaken = BrTaken;

    mc_decoder u_decoder (
        .opcode  (Opcode),
        .funct3  (Funct3),
        .funct7  (Funct7),
        .dec     (dec_w),
        .illegal (illegal_w)
    );

    // State sequencing plus decode-field capture in DECODE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= ST_FETCH;
            dec_reg     <= '0;
            illegal_reg <= 1'b0;
        end else begin
            case (state_reg)
                ST_FETCH: if (IMemReady) state_reg <= ST_DECODE;
                ST_DECODE: begin
                    dec_reg <= dec_w;
                    if (illegal_w) begin
                        illegal_reg <= 1'b1;
                        state_reg   <= ST_TRAP;
                    end else begin
                        state_reg <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    if (dec_reg.is_load || dec_reg.is_store) state_reg <= ST_MEM;
                    else if (dec_reg.is_branch)              state_reg <= ST_FETCH;
                    else                                     state_reg <= ST_WB;
                end
                ST_MEM: begin
                    if (DMemReady) state_reg <= dec_reg.is_load ? ST_WB : ST_FETCH;
                end
                ST_WB:   state_reg <= ST_FETCH;
                ST_TRAP: state_reg <= ST_TRAP;
                default: state_reg <= ST_FETCH;
            endcase
        end
    end

    // Strobes follow the current state (and handshakes) within the same cycle;
    // gating with rst_n keeps them low for the whole reset interval
    always_comb begin
        PCWr  = 1'b0;
        IRWr  = 1'b0;
        RUWr  = 1'b0;
        DMReq = 1'b0;
        DMWr  = 1'b0;
        if (rst_n) begin
            case (state_reg)
                ST_FETCH: IRWr = IMemReady;
                ST_EXEC:  PCWr = dec_reg.is_branch;
                ST_MEM: begin
                    DMReq = 1'b1;
                    DMWr  = dec_reg.is_store;
                    PCWr  = dec_reg.is_store && DMemReady;
                end
                ST_WB: begin
                    RUWr = 1'b1;
                    PCWr = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign ImmSrc      = dec_reg.imm_src;
    assign ALUASrc     = dec_reg.alu_a_src;
    assign ALUBSrc     = dec_reg.alu_b_src;
    assign BrOp        = dec_reg.br_op;
    assign ALUOp       = dec_reg.alu_op;
    assign DMCtrl      = dec_reg.dm_ctrl;
    assign RUDataWrSrc = dec_reg.wr_src;
    assign Illegal     = illegal_reg;
    assign State       = state_reg;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed testbench for multicycle_ctrl: per-cycle strobe/state sequences and
// latched decode fields for representative instructions, traps and resets.
module tb_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [6:0] Opcode;
    logic [2:0] Funct3;
    logic [6:0] Funct7;
    logic       IMemReady;
    logic       DMemReady;
    logic       BrTaken;
    logic       PCWr, IRWr, RUWr, DMReq, DMWr;
    logic [2:0] ImmSrc;
    logic       ALUASrc, ALUBSrc;
    logic [4:0] BrOp;
    logic [3:0] ALUOp;
    logic [2:0] DMCtrl;
    logic [1:0] RUDataWrSrc;
    logic       Illegal;
    logic [2:0] State;

    int checks   = 0;
    int failures = 0;

    // Per-cycle record: {PCWr,IRWr,RUWr,DMReq,DMWr} and State
    logic [4:0] sb [8];
    logic [2:0] st [8];

    always #5 clk = ~clk;

    multicycle_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .Opcode      (Opcode),
        .Funct3      (Funct3),
        .Funct7      (Funct7),
        .IMemReady   (IMemReady),
        .DMemReady   (DMemReady),
        .BrTaken     (BrTaken),
        .PCWr        (PCWr),
        .IRWr        (IRWr),
        .RUWr        (RUWr),
        .DMReq       (DMReq),
        .DMWr        (DMWr),
        .ImmSrc      (ImmSrc),
        .ALUASrc     (ALUASrc),
        .ALUBSrc     (ALUBSrc),
        .BrOp        (BrOp),
        .ALUOp       (ALUOp),
        .DMCtrl      (DMCtrl),
        .RUDataWrSrc (RUDataWrSrc),
        .Illegal     (Illegal),
        .State       (State)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Called at posedge+1; leaves at posedge+1 after n cycles.
    // IMemReady pulses in cycle 0; DMemReady is high from cycle ready_at on.
    task automatic run(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                       input int n, input int ready_at);
        Opcode = op;
        Funct3 = f3;
        Funct7 = f7;
        for (int c = 0; c < n; c++) begin
            IMemReady = (c == 0);
            DMemReady = (c >= ready_at);
            @(negedge clk);
            sb[c] = {PCWr, IRWr, RUWr, DMReq, DMWr};
            st[c] = State;
            @(posedge clk);
            #1;
        end
        IMemReady = 1'b0;
        DMemReady = 1'b0;
        $display("instr op=%b f3=%b f7=%b cycles=%0d state_now=%0d", op, f3, f7, n, State);
    endtask

    // Expected vectors are listed cycle 0 first (most significant)
    task automatic verify(input string tag, input int n, input logic [39:0] esb, input logic [23:0] est);
        for (int c = 0; c < n; c++) begin
            check($sformatf("%s.strobe%0d", tag, c), 32'(sb[c]), 32'(esb[39-5*c -: 5]));
            check($sformatf("%s.state%0d", tag, c), 32'(st[c]), 32'(est[23-3*c -: 3]));
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        IMemReady = 1'b1;
        #2;
        check("rst.state", 32'(State), 32'd0);
        check("rst.illegal", 32'(Illegal), 32'd0);
        check("rst.strobes", 32'({PCWr, IRWr, RUWr, DMReq, DMWr}), 32'd0);
        check("rst.brop", 32'(BrOp), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        IMemReady = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; Opcode = '0; Funct3 = '0; Funct7 = '0;
        IMemReady = 1'b0; DMemReady = 1'b0; BrTaken = 1'b0;
        @(posedge clk); #1;
        do_reset();

        // add: IRWr c0, RUWr+PCWr c3
        run(7'b0110011, 3'b000, 7'b0000000, 5, 0);
        verify("add", 5, {5'b01000, 5'b00000, 5'b00000, 5'b10100, 5'b00000, 15'b0},
                         {3'd0, 3'd1, 3'd2, 3'd4, 3'd0, 9'b0});
        check("add.aluop", 32'(ALUOp), 32'h0);
        check("add.wrsrc", 32'(RUDataWrSrc), 32'h0);
        check("add.bsrc", 32'(ALUBSrc), 32'h0);
        check("add.brop", 32'(BrOp), 32'b10101);

        // lw with two wait cycles: DMReq c3..c5, RUWr c6
        run(7'b0000011, 3'b010, 7'b0000000, 8, 5);
        verify("lw", 8, {5'b01000, 5'b00000, 5'b00000, 5'b00010, 5'b00010, 5'b00010, 5'b10100, 5'b00000},
                        {3'd0, 3'd1, 3'd2, 3'd3, 3'd3, 3'd3, 3'd4, 3'd0});
        check("lw.dmctrl", 32'(DMCtrl), 32'b010);
        check("lw.wrsrc", 32'(RUDataWrSrc), 32'b01);
        check("lw.immsrc", 32'(ImmSrc), 32'b000);
        check("lw.bsrc", 32'(ALUBSrc), 32'h1);

        // sw zero wait: DMReq+DMWr+PCWr c3, no RUWr
        run(7'b0100011, 3'b010, 7'b0000000, 5, 3);
        verify("sw", 5, {5'b01000, 5'b00000, 5'b00000, 5'b10011, 5'b00000, 15'b0},
                        {3'd0, 3'd1, 3'd2, 3'd3, 3'd0, 9'b0});
        check("sw.immsrc", 32'(ImmSrc), 32'b001);
        check("sw.dmctrl", 32'(DMCtrl), 32'b010);

        // bne: PCWr in EXEC c2, FETCH again c3
        run(7'b1100011, 3'b001, 7'b0000000, 4, 0);
        verify("bne", 4, {5'b01000, 5'b00000, 5'b10000, 5'b00000, 20'b0},
                         {3'd0, 3'd1, 3'd2, 3'd0, 12'b0});
        check("bne.brop", 32'(BrOp), 32'b00001);
        check("bne.immsrc", 32'(ImmSrc), 32'b010);
        check("bne.asrc", 32'(ALUASrc), 32'h1);

        // jal
        run(7'b1101111, 3'b000, 7'b0000000, 5, 0);
        verify("jal", 5, {5'b01000, 5'b00000, 5'b00000, 5'b10100, 5'b00000, 15'b0},
                         {3'd0, 3'd1, 3'd2, 3'd4, 3'd0, 9'b0});
        check("jal.brop", 32'(BrOp), 32'b01111);
        check("jal.immsrc", 32'(ImmSrc), 32'b100);
        check("jal.wrsrc", 32'(RUDataWrSrc), 32'b10);
        check("jal.asrc", 32'(ALUASrc), 32'h1);

        // sub, sra, srai, xori, lui, auipc decode fields
        run(7'b0110011, 3'b000, 7'b0100000, 5, 0);
        check("sub.aluop", 32'(ALUOp), 32'b1000);
        run(7'b0110011, 3'b101, 7'b0100000, 5, 0);
        check("sra.aluop", 32'(ALUOp), 32'b1101);
        run(7'b0010011, 3'b101, 7'b0100000, 5, 0);
        check("srai.aluop", 32'(ALUOp), 32'b1101);
        check("srai.bsrc", 32'(ALUBSrc), 32'h1);
        run(7'b0010011, 3'b100, 7'b0000000, 5, 0);
        check("xori.aluop", 32'(ALUOp), 32'b0100);
        run(7'b0110111, 3'b000, 7'b0000000, 5, 0);
        check("lui.immsrc", 32'(ImmSrc), 32'b011);
        check("lui.asrc", 32'(ALUASrc), 32'h0);
        check("lui.aluop", 32'(ALUOp), 32'h0);
        check("lui.state", 32'(st[3]), 32'd4);
        run(7'b0010111, 3'b000, 7'b0000000, 5, 0);
        check("auipc.asrc", 32'(ALUASrc), 32'h1);

        // Opcode 1111111: TRAP from c2, held with Illegal=1
        run(7'b1111111, 3'b000, 7'b0000000, 3, 0);
        verify("trap", 3, {5'b01000, 5'b00000, 5'b00000, 25'b0},
                          {3'd0, 3'd1, 3'd7, 15'b0});
        IMemReady = 1'b1;
        DMemReady = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            check($sformatf("trap.hold%0d.state", c), 32'(State), 32'd7);
            check($sformatf("trap.hold%0d.strobes", c), 32'({PCWr, IRWr, RUWr, DMReq, DMWr}), 32'd0);
            check($sformatf("trap.hold%0d.illegal", c), 32'(Illegal), 32'h1);
        end
        @(posedge clk); #1;
        do_reset();

        // R-type with alternate funct7 on sll is illegal
        run(7'b0110011, 3'b001, 7'b0100000, 3, 0);
        check("badr.state", 32'(st[2]), 32'd7);
        check("badr.illegal", 32'(Illegal), 32'h1);
        do_reset();

        // Load funct3 011 is illegal
        run(7'b0000011, 3'b011, 7'b0000000, 3, 0);
        check("badld.state", 32'(st[2]), 32'd7);
        do_reset();

        // Reset in the middle of a stalled sw
        run(7'b0100011, 3'b000, 7'b0000000, 4, 99);
        check("swrst.pre_dmreq", 32'(DMReq), 32'h1);
        check("swrst.pre_dmwr", 32'(DMWr), 32'h1);
        rst_n = 1'b0;
        #1;
        check("swrst.dmreq", 32'(DMReq), 32'h0);
        check("swrst.dmwr", 32'(DMWr), 32'h0);
        check("swrst.state", 32'(State), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Back to normal operation after reset
        run(7'b0110011, 3'b111, 7'b0000000, 5, 0);
        verify("and", 5, {5'b01000, 5'b00000, 5'b00000, 5'b10100, 5'b00000, 15'b0},
                         {3'd0, 3'd1, 3'd2, 3'd4, 3'd0, 9'b0});
        check("and.aluop", 32'(ALUOp), 32'b0111);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 SHALL: clk  in  1  rising-edge clock; one clock.
REQ-002 SHALL: rst_n  in  1  reset, asynchronous, active-low.
REQ-003 SHALL: Opcode  in  7  instruction-register opcode field.
REQ-004 SHALL: Funct3  in  3  instruction-register funct3.
REQ-005 SHALL: Funct7  in  7  instruction-register funct7.
REQ-006 SHALL: IMemReady  in  1  instruction word valid this cycle.
REQ-007 SHALL: DMemReady  in  1  data-memory access complete this cycle.
REQ-008 SHALL: BrTaken  in  1  branch-unit compare result.
REQ-009 SHALL: PCWr, IRWr, RUWr, DMReq, DMWr  out  1 each  state-qualified write/request strobes.
REQ-010 SHALL: ImmSrc 3, ALUASrc 1, ALUBSrc 1, BrOp 5, ALUOp 4, DMCtrl 3, RUDataWrSrc 2  out  registered decode fields.
REQ-011 SHALL: Illegal  out  1  sticky illegal-instruction flag; State  out  3  current state (debug).

Function
REQ-012 SHALL: states FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=7; others -> FETCH next cycle.
REQ-013 SHALL: FETCH holds while IMemReady=0; when IMemReady=1, IRWr=1 for that cycle, next DECODE.
REQ-014 SHALL: DECODE registers all REQ-010 fields; they stay stable until the next DECODE.
REQ-015 SHALL: DECODE goes to TRAP on unknown opcode, undefined load/store/branch funct3, or R-type funct7 not 0000000/0100000 (0100000 legal only with funct3 000/101); else EXEC.
REQ-016 SHALL: EXEC -> MEM for load/store; branch -> FETCH with PCWr=1 in EXEC; all others -> WB.
REQ-017 SHALL: MEM holds DMReq=1 (DMWr=1 for stores) until DMemReady=1; then load -> WB, store -> FETCH with PCWr=1.
REQ-018 SHALL: WB asserts RUWr=1 and PCWr=1 for exactly one cycle, then FETCH.
REQ-019 SHALL: PCWr, IRWr, RUWr, DMReq, DMWr = 0 in every state/condition not named above.
REQ-020 SHALL: ALUOp: add 0000, sub 1000, sll 0001, slt 0010, sltu 0011, xor 0100, srl 0101, sra 1101, or 0110, and 0111; I-type funct3=101 selects sra when Funct7[5]=1; load/store/jump/U-type use add.
REQ-021 SHALL: ImmSrc I=000, S=001, B=010, U=011, J=100; R-type 000.
REQ-022 SHALL: ALUASrc=1 (PC) for branch, jal, auipc; ALUBSrc=1 (imm) for all but R-type.
REQ-023 SHALL: BrOp = {2'b00,Funct3} for branches, 01111 for jal/jalr, 10101 otherwise.
REQ-024 SHALL: RUDataWrSrc 00 ALU, 01 memory (loads), 10 PC+4 (jal/jalr); DMCtrl = Funct3 for load/store, else 000.
REQ-025 SHALL: lui drives ALUASrc=0 with operand-A zero-select handled externally; ALUOp add.
REQ-026 SHALL: latency with zero wait: branch 3, R/I/U/jal/jalr 4, store 4, load 5 cycles; each wait cycle adds one.
REQ-027 SHALL: TRAP holds all strobes 0 and Illegal=1 until reset.
REQ-028 SHALL: PCWr pulses exactly once per legal instruction.

Reset
REQ-029 SHALL: rst_n=0 immediately forces FETCH, all outputs 0, Illegal=0, including mid-MEM (DMReq drops without waiting).
REQ-030 SHALL: first FETCH begins on the first rising clk after rst_n deasserts.

Structure
REQ-031 SHALL: package mc_pkg holds state enum, opcode constants, ALUOp/ImmSrc/BrOp/RUDataWrSrc encodings.
REQ-032 SHALL: combinational sub-module mc_decoder maps Opcode/Funct3/Funct7 to decode fields + illegal; FSM registers its outputs in DECODE.

Verification
REQ-033 SHALL: add x (0110011/000/0000000), IMemReady=1 -> IRWr cycle 0, RUWr=PCWr=1 cycle 3, ALUOp=0000, RUDataWrSrc=00.
REQ-034 SHALL: lw (0000011/010), DMemReady low 2 cycles -> DMReq high 3 cycles, DMCtrl=010, RUWr in cycle 6, RUDataWrSrc=01.
REQ-035 SHALL: sw (0100011/010) -> DMWr=DMReq=1 in MEM, PCWr with DMemReady, RUWr never 1, ImmSrc=001.
REQ-036 SHALL: bne (1100011/001) -> BrOp=00001, ImmSrc=010, PCWr in EXEC (cycle 2), back to FETCH cycle 3.
REQ-037 SHALL: opcode 1111111 -> TRAP from cycle 2, Illegal=1, all strobes 0 for 20 cycles; rst_n pulse clears.
REQ-038 SHALL: rst_n asserted mid-MEM of sw -> DMReq/DMWr drop same cycle, State=0.
